tetris_display_ctrl: RTL and testbench

//  Sequences the HDMI pixel datapath for the Tetris playfield: generates 640x480@60 timing on pixclk,

---
 rtl/tetris_video_pkg.sv | 52 +++++
 rtl/video_timing_gen.sv | 69 ++++++
 rtl/tetris_display_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tetris_display_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_video_pkg.sv
// ============================================================================
//  Module : tetris_video_pkg
//  Brief  : Shared video timing defaults, playfield geometry, cell colour type
//           and the colour-index palette for the Tetris display path.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tetris_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_BOARD_X0 = 240;
    localparam int DEF_BOARD_Y0 = 80;
    localparam int DEF_CELL_PX  = 16;
    localparam int DEF_BOARD_W  = 10;
    localparam int DEF_BOARD_H  = 20;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 8;

    typedef logic [2:0]  cell_idx_t;
    typedef logic [23:0] rgb_t;

    localparam rgb_t GRID_RGB = 24'h404040;

    // Index 0 is an empty cell and shows as white.
    function automatic rgb_t palette(input cell_idx_t idx);
        rgb_t v_rgb;
        case (idx)
            3'd0:    v_rgb = 24'hFFFFFF;
            3'd1:    v_rgb = 24'hFF0000;
            3'd2:    v_rgb = 24'h00FF00;
            3'd3:    v_rgb = 24'h0000FF;
            3'd4:    v_rgb = 24'hFFFF00;
            3'd5:    v_rgb = 24'hFF00FF;
            3'd6:    v_rgb = 24'h00FFFF;
            default: v_rgb = 24'hFF8000;
        endcase
        return v_rgb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
//  Module : video_timing_gen
//  Brief  : Horizontal/vertical pixel counters with decoded sync, active and
//           frame-start flags, all aligned to the current counter values.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module video_timing_gen
    import tetris_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             pixclk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_hc,
    output logic [CNT_W-1:0] o_vc,
    output logic             o_active,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_frame_start
);

    localparam logic [CNT_W-1:0] c_H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_H_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] c_HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] c_VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (r_hc == c_H_LAST);
    assign w_v_last = (r_vc == c_V_LAST);

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_h_last) begin
            r_hc <= '0;
            r_vc <= w_v_last ? '0 : r_vc + 1'b1;
        end else begin
            r_hc <= r_hc + 1'b1;
        end
    end

    assign o_hc          = r_hc;
    assign o_vc          = r_vc;
    assign o_active      = (r_hc < c_H_ACT) && (r_vc < c_V_ACT);
    assign o_hsync       = !((r_hc >= c_HS_BEG) && (r_hc < c_HS_END));
    assign o_vsync       = !((r_vc >= c_VS_BEG) && (r_vc < c_VS_END));
    assign o_frame_start = (r_hc == '0) && (r_vc == '0);

endmodule

`default_nettype wire

// File: rtl/tetris_display_ctrl.sv
// ============================================================================
//  Module : tetris_display_ctrl
//  Brief  : 640x480 HDMI pixel sequencer for the Tetris playfield with cell-RAM
//           arbitration (display has priority, game writes via req/ack).
//           Optional macro GRID_LINES_EN draws 404040 grid lines on cell edges.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tetris_display_ctrl
    import tetris_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int BOARD_X0 = DEF_BOARD_X0,
    parameter int BOARD_Y0 = DEF_BOARD_Y0,
    parameter int CELL_PX  = DEF_CELL_PX,
    parameter int BOARD_W  = DEF_BOARD_W,
    parameter int BOARD_H  = DEF_BOARD_H
) (
    input  logic              pixclk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [2:0]        ram_wdata,
    input  logic [2:0]        ram_rdata,
    output logic [7:0]        R_data,
    output logic [7:0]        G_data,
    output logic [7:0]        B_data,
    output logic              VDE,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int               c_CELL_SH = $clog2(CELL_PX);
    localparam logic [CNT_W-1:0] c_X0      = CNT_W'(BOARD_X0);
    localparam logic [CNT_W-1:0] c_X1      = CNT_W'(BOARD_X0 + BOARD_W * CELL_PX);
    localparam logic [CNT_W-1:0] c_Y0      = CNT_W'(BOARD_Y0);
    localparam logic [CNT_W-1:0] c_Y1      = CNT_W'(BOARD_Y0 + BOARD_H * CELL_PX);
    localparam logic [ADDR_W-1:0] c_BW     = ADDR_W'(BOARD_W);
    localparam logic [ADDR_W-1:0] c_CELLS  = ADDR_W'(BOARD_W * BOARD_H);

    logic [CNT_W-1:0]  w_hc;
    logic [CNT_W-1:0]  w_vc;
    logic              w_active;
    logic              w_hsync;
    logic              w_vsync;
    logic              w_frame_start;
    logic [CNT_W-1:0]  w_bx;
    logic [CNT_W-1:0]  w_by;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_cell_addr;
    logic              w_disp_slot;
    rgb_t              w_pix_rgb;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .pixclk        (pixclk),
        .rst_n         (rst_n),
        .o_hc          (w_hc),
        .o_vc          (w_vc),
        .o_active      (w_active),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_frame_start (w_frame_start)
    );

    assign w_bx        = w_hc - c_X0;
    assign w_by        = w_vc - c_Y0;
    assign w_col       = ADDR_W'(w_bx >> c_CELL_SH);
    assign w_row       = ADDR_W'(w_by >> c_CELL_SH);
    assign w_cell_addr = w_row * c_BW + w_col;
    assign w_disp_slot = (w_hc >= c_X0) && (w_hc < c_X1) && (w_vc >= c_Y0) && (w_vc < c_Y1);

    // Game writes fill every cycle the display is not reading; nothing is granted while in reset.
    assign wr_ack    = rst_n && wr_req && !w_disp_slot;
    assign ram_we    = wr_ack && (wr_addr < c_CELLS);
    assign ram_addr  = w_disp_slot ? w_cell_addr : wr_addr;
    assign ram_wdata = wr_data;

    logic r_s1_active;
    logic r_s1_in_board;
    logic r_s1_hsync;
    logic r_s1_vsync;
    logic r_s1_frame_start;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_active      <= 1'b0;
            r_s1_in_board    <= 1'b0;
            r_s1_hsync       <= 1'b1;
            r_s1_vsync       <= 1'b1;
            r_s1_frame_start <= 1'b0;
        end else begin
            r_s1_active      <= w_active;
            r_s1_in_board    <= w_disp_slot;
            r_s1_hsync       <= w_hsync;
            r_s1_vsync       <= w_vsync;
            r_s1_frame_start <= w_frame_start;
        end
    end

`ifdef GRID_LINES_EN
    logic r_s1_grid;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_grid <= 1'b0;
        end else begin
            r_s1_grid <= (w_bx[c_CELL_SH-1:0] == '0) || (w_by[c_CELL_SH-1:0] == '0);
        end
    end
`endif

    // ram_rdata arrives in stage 1, aligned with the delayed control flags.
    always_comb begin
        w_pix_rgb = '0;
        if (r_s1_active && r_s1_in_board) begin
            w_pix_rgb = palette(cell_idx_t'(ram_rdata));
`ifdef GRID_LINES_EN
            if (r_s1_grid) begin
                w_pix_rgb = GRID_RGB;
            end
`endif
        end
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            R_data      <= '0;
            G_data      <= '0;
            B_data      <= '0;
            VDE         <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            R_data      <= w_pix_rgb[23:16];
            G_data      <= w_pix_rgb[15:8];
            B_data      <= w_pix_rgb[7:0];
            VDE         <= r_s1_active;
            hsync       <= r_s1_hsync;
            vsync       <= r_s1_vsync;
            frame_start <= r_s1_frame_start;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tetris_display_ctrl.sv
// ============================================================================
//  Module : tb_tetris_display_ctrl
//  Brief  : Self-checking bench for tetris_display_ctrl on a scaled-down raster
//           (80x56 total, 64x48 active, 20x40 px board of 2 px cells).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tetris_display_ctrl;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 4;
    localparam int X0 = 8, Y0 = 4, C = 2, BW = 10, BH = 20;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [27:0] RST_OUT = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic [23:0] rgb;
        logic        vde;
        logic        hs;
        logic        vs;
        logic        fs;
    } pix_t;

    logic       pixclk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [2:0] wr_data;
    logic       wr_ack;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata;
    logic [7:0] R_data, G_data, B_data;
    logic       VDE, hsync, vsync, frame_start;

    logic [2:0] mem       [0:255];
    logic [2:0] exp_board [0:255];
    pix_t       q[$];
    int         cyc;
    int         we_cnt;
    int         checks = 0;
    int         errors = 0;

    always #5 pixclk = ~pixclk;

    tetris_display_ctrl #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .BOARD_X0 (X0), .BOARD_Y0 (Y0), .CELL_PX (C), .BOARD_W (BW), .BOARD_H (BH)
    ) dut (
        .pixclk      (pixclk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .R_data      (R_data),
        .G_data      (G_data),
        .B_data      (B_data),
        .VDE         (VDE),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    // Synchronous single-port cell RAM
    always @(posedge pixclk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 3'd0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pal(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFF0000;
            3'd2:    return 24'h00FF00;
            3'd3:    return 24'h0000FF;
            3'd4:    return 24'hFFFF00;
            3'd5:    return 24'hFF00FF;
            3'd6:    return 24'h00FFFF;
            default: return 24'hFF8000;
        endcase
    endfunction

    function automatic bit in_board(input int hc, input int vc);
        return hc >= X0 && hc < X0 + BW * C && vc >= Y0 && vc < Y0 + BH * C;
    endfunction

    function automatic int cell_of(input int hc, input int vc);
        return ((vc - Y0) / C) * BW + (hc - X0) / C;
    endfunction

    // What the encoder must see for raster position n (cycles since reset release)
    function automatic pix_t model_pix(input int n);
        int   hc, vc;
        pix_t e;
        hc    = n % HT;
        vc    = (n / HT) % VT;
        e.vde = (hc < HA) && (vc < VA);
        e.hs  = !(hc >= HA + HF && hc < HA + HF + HS);
        e.vs  = !(vc >= VA + VF && vc < VA + VF + VS);
        e.fs  = (hc == 0) && (vc == 0);
        e.rgb = 24'h0;
        if (e.vde && in_board(hc, vc)) begin
            e.rgb = pal(exp_board[cell_of(hc, vc)]);
`ifdef GRID_LINES_EN
            if ((hc - X0) % C == 0 || (vc - Y0) % C == 0) e.rgb = 24'h404040;
`endif
        end
        return e;
    endfunction

    function automatic logic [9:0] model_arb(input int n);
        int hc, vc;
        bit disp, ack, we;
        int addr;
        hc   = n % HT;
        vc   = (n / HT) % VT;
        disp = in_board(hc, vc);
        ack  = wr_req && !disp;
        we   = ack && (wr_addr < 8'd200);
        addr = disp ? cell_of(hc, vc) : int'(wr_addr);
        return {ack, we, addr[7:0]};
    endfunction

    always @(negedge pixclk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) exp_board[i] <= 3'd0;
        end
        if (!rst_n) begin
            q.delete();
            chk("reset_outputs", {R_data, G_data, B_data, VDE, hsync, vsync, frame_start}, RST_OUT);
            chk("reset_no_grant", {wr_ack, ram_we}, 2'b00);
        end else begin
            chk("arbiter", {wr_ack, ram_we, ram_addr}, model_arb(cyc));
            q.push_back(model_pix(cyc));
            if (q.size() > 2)
                chk("pixel", {R_data, G_data, B_data, VDE, hsync, vsync, frame_start}, q.pop_front());
            else
                chk("pipe_fill", {R_data, G_data, B_data, VDE, hsync, vsync, frame_start}, RST_OUT);
            if (wr_req && !in_board(cyc % HT, (cyc / HT) % VT) && wr_addr < 8'd200)
                exp_board[wr_addr] <= wr_data;
            if (ram_we) we_cnt <= we_cnt + 1;
        end
    end

    task automatic wait_hv(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(negedge pixclk);
            n++;
        end while (!((cyc % HT) == h && ((cyc / HT) % VT) == v) && n < 2 * FRAME);
        if (n >= 2 * FRAME) chk("wait_hv_timeout", 64'(n), 64'(0));
    endtask

    task automatic pix_at(input string name, input int x, input int y,
                          input logic [23:0] rgb, input logic vde);
        wait_hv(x, y);
        repeat (2) @(negedge pixclk);
        chk(name, {R_data, G_data, B_data, VDE}, {rgb, vde});
    endtask

    task automatic write_at(input string name, input int h, input int v,
                            input logic [7:0] a, input logic [2:0] d, input logic exp_we);
        wait_hv(h - 1, v);
        @(posedge pixclk);
        #1;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge pixclk);
        chk(name, {wr_ack, ram_we, ram_addr, ram_wdata}, {1'b1, exp_we, a, d});
        @(posedge pixclk);
        #1;
        wr_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hs_low, vs_low, we0;
        clr     = 1'b1;
        rst_n   = 1'b0;
        we_cnt  = 0;
        wr_req  = 1'b1;
        wr_addr = 8'd0;
        wr_data = 3'd1;
        repeat (3) @(posedge pixclk);
        #1;
        clr = 1'b0;
        @(negedge pixclk);
        chk("rst_lit_out", {R_data, G_data, B_data, VDE, hsync, vsync, frame_start, ram_we}, {RST_OUT, 1'b0});
        chk("rst_lit_ack", wr_ack, 1'b0);

        // Request held through reset is granted on the first cycle after release
        @(posedge pixclk);
        #1;
        rst_n = 1'b1;
        @(negedge pixclk);
        chk("pending_ack", {wr_ack, ram_we, ram_addr}, {1'b1, 1'b1, 8'd0});
        @(posedge pixclk);
        #1;
        wr_req = 1'b0;

        n = 0;
        while (!frame_start && n < 10) begin @(negedge pixclk); n++; end
        chk("first_fs_cycle", 64'(cyc), 64'(2));

        n = 0; hs_low = 0; vs_low = 0;
        do begin
            @(negedge pixclk);
            n++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
        end while (!frame_start && n < 2 * FRAME);
        chk("frame_len", 64'(n), 64'(4480));
        chk("hsync_low_cycles", 64'(hs_low), 64'(448));
        chk("vsync_low_cycles", 64'(vs_low), 64'(160));

        pix_at("left_of_board", 7, 4, 24'h000000, 1'b1);
`ifdef GRID_LINES_EN
        pix_at("board_origin", 8, 4, 24'h404040, 1'b1);
`else
        pix_at("board_origin", 8, 4, 24'hFF0000, 1'b1);
`endif
        pix_at("cell0_inner", 9, 5, 24'hFF0000, 1'b1);

        write_at("outside_ack", 70, 2, 8'd5, 3'd3, 1'b1);
        write_at("cell0_write", 70, 3, 8'd0, 3'd2, 1'b1);
        write_at("oob_dropped", 70, 4, 8'd200, 3'd7, 1'b0);

        // Request inside the display slot waits until the slot ends
        wait_hv(9, 10);
        @(posedge pixclk);
        #1;
        wr_req  = 1'b1;
        wr_addr = 8'd7;
        wr_data = 3'd4;
        we0     = we_cnt;
        n       = 0;
        @(negedge pixclk);
        while (!wr_ack && n < 1000) begin n++; @(negedge pixclk); end
        chk("ack_wait", 64'(n), 64'(18));
        chk("ack_hc", 64'(cyc % HT), 64'(28));
        @(posedge pixclk);
        #1;
        wr_req = 1'b0;
        @(negedge pixclk);
        chk("single_write", 64'(we_cnt - we0), 64'(1));

`ifdef GRID_LINES_EN
        pix_at("grid_origin", 8, 4, 24'h404040, 1'b1);
`else
        pix_at("grid_origin", 8, 4, 24'h00FF00, 1'b1);
`endif
        pix_at("cell0_green", 9, 5, 24'h00FF00, 1'b1);
        pix_at("cell5_blue", 19, 5, 24'h0000FF, 1'b1);
        pix_at("cell7_yellow", 23, 5, 24'hFFFF00, 1'b1);

        // Asynchronous reset in the middle of a frame
        wait_hv(29, 20);
        @(posedge pixclk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {R_data, G_data, B_data, VDE, hsync, vsync, frame_start}, RST_OUT);
        @(posedge pixclk);
        @(posedge pixclk);
        #1;
        rst_n = 1'b1;
        n = 0;
        @(negedge pixclk);
        while (!frame_start && n < 10) begin n++; @(negedge pixclk); end
        chk("fs_after_reset", 64'(n), 64'(2));
        pix_at("board_kept", 9, 5, 24'h00FF00, 1'b1);

        repeat (10) @(negedge pixclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
